// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters with registered sync, de and end flags.
// Optional frame counter output is enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_end,
  output logic          frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if ((H_VISIBLE < 1) || (H_FRONT < 1) || (H_SYNC < 1) || (H_BACK < 1)) begin : g_bad_h_span
    $error("vga_timing_gen: every horizontal span must be at least 1");
  end
  if ((V_VISIBLE < 1) || (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1)) begin : g_bad_v_span
    $error("vga_timing_gen: every vertical span must be at least 1");
  end
  if (longint'(H_TOTAL - 1) >= (longint'(1) << CW)) begin : g_bad_h_width
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
  end
  if (longint'(V_TOTAL - 1) >= (longint'(1) << CW)) begin : g_bad_v_width
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
  end

  // All boundaries are strictly below the totals, so they fit in CW bits.
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_end_q, line_end_d;
  logic          frame_end_q, frame_end_d;
  logic          frame_wrap;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  assign frame_wrap = (h_q == H_LAST) && (v_q == V_LAST);

  // Decoding the next-state counters keeps every flag aligned with the counter it describes.
  always_comb begin
    hsync_d     = ((h_d >= HS_START) && (h_d < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d     = ((v_d >= VS_START) && (v_d < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    de_d        = (h_d < H_VIS) && (v_d < V_VIS);
    line_end_d  = (h_d == H_LAST);
    frame_end_d = (h_d == H_LAST) && (v_d == V_LAST);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      hsync_q     <= ~H_SYNC_POL;
      vsync_q     <= ~V_SYNC_POL;
      de_q        <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else if (en) begin
      h_q         <= h_d;
      v_q         <= v_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign h_count   = h_q;
  assign v_count   = v_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      frame_cnt_q <= 16'd0;
    end else if (en) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a tiny-timing instance share clk/en/reset.
// Expected values come from the count of enabled edges since reset, mapped to raster position arithmetically.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n;
  logic en;

  logic [9:0] a_h, a_v;
  logic       a_hs, a_vs, a_de, a_le, a_fe;
  logic [3:0] b_h, b_v;
  logic       b_hs, b_vs, b_de, b_le, b_fe;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  vga_timing_gen dut_a (
    .clk(clk), .arst_n(arst_n), .en(en),
    .h_count(a_h), .v_count(a_v), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .line_end(a_le), .frame_end(a_fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(4)
  ) dut_b (
    .clk(clk), .arst_n(arst_n), .en(en),
    .h_count(b_h), .v_count(b_v), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .line_end(b_le), .frame_end(b_fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  typedef struct {
    int h, v;
    bit hs, vs, de, le, fe;
  } exp_t;

  typedef struct {
    bit en;
    int h, v;
    bit hs, vs, de, le, fe;
  } vec_t;

  int     compared   = 0;
  int     mismatched = 0;
  longint n          = 0;   // enabled edges since the last reset release
  longint fc_start   = 0;   // frame counter value represented by n = 0

  // Raster position after n enabled edges; n = 0 means no enabled edge yet (reset values).
  function automatic exp_t model(longint cnt, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, bit hp, bit vp);
    exp_t e;
    int ht = hv + hf + hsw + hb;
    int vt = vv + vf + vsw + vb;
    if (cnt == 0) begin
      e = '{h: 0, v: 0, hs: ~hp, vs: ~vp, de: 1'b0, le: 1'b0, fe: 1'b0};
      return e;
    end
    e.h  = int'(cnt % ht);
    e.v  = int'((cnt / ht) % vt);
    e.hs = (e.h >= hv + hf && e.h < hv + hf + hsw) ? hp : ~hp;
    e.vs = (e.v >= vv + vf && e.v < vv + vf + vsw) ? vp : ~vp;
    e.de = (e.h < hv) && (e.v < vv);
    e.le = (e.h == ht - 1);
    e.fe = e.le && (e.v == vt - 1);
    return e;
  endfunction

  task automatic cmp(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t, n=%0d)", name, act, exp, $time, n);
    end
  endtask

  task automatic check_all();
    exp_t ea, eb;
    ea = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    eb = model(n, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    cmp("a.h_count", a_h, ea.h);   cmp("a.v_count", a_v, ea.v);
    cmp("a.hsync", a_hs, ea.hs);   cmp("a.vsync", a_vs, ea.vs);
    cmp("a.de", a_de, ea.de);      cmp("a.line_end", a_le, ea.le);
    cmp("a.frame_end", a_fe, ea.fe);
    cmp("b.h_count", b_h, eb.h);   cmp("b.v_count", b_v, eb.v);
    cmp("b.hsync", b_hs, eb.hs);   cmp("b.vsync", b_vs, eb.vs);
    cmp("b.de", b_de, eb.de);      cmp("b.line_end", b_le, eb.le);
    cmp("b.frame_end", b_fe, eb.fe);
`ifdef VGA_TIMING_FRAME_CNT_EN
    cmp("a.frame_cnt", a_fc, (n / 420000) % 65536);
    cmp("b.frame_cnt", b_fc, (fc_start + n / 48) % 65536);
`endif
  endtask

  // One clock: drive en, count the edge if enabled, sample 1 time unit after the edge.
  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    if (e && arst_n) n++;
    #1;
    check_all();
    $display("step n=%0d en=%0b a=(%0d,%0d) b=(%0d,%0d)", n, e, a_h, a_v, b_h, b_v);
  endtask

  vec_t tbl[11];
  int   de_cnt, fe_cnt, le_cnt, hs_cnt, vs_cnt;
  bit   found;

  initial begin
    // Small-timing instance straight after reset: H_TOTAL=8 (hsync at 5,6), V_TOTAL=6.
    tbl[0]  = '{en: 1'b0, h: 0, v: 0, hs: 1'b0, vs: 1'b0, de: 1'b0, le: 1'b0, fe: 1'b0};
    tbl[1]  = '{en: 1'b1, h: 1, v: 0, hs: 1'b0, vs: 1'b0, de: 1'b1, le: 1'b0, fe: 1'b0};
    tbl[2]  = '{en: 1'b1, h: 2, v: 0, hs: 1'b0, vs: 1'b0, de: 1'b1, le: 1'b0, fe: 1'b0};
    tbl[3]  = '{en: 1'b0, h: 2, v: 0, hs: 1'b0, vs: 1'b0, de: 1'b1, le: 1'b0, fe: 1'b0};
    tbl[4]  = '{en: 1'b1, h: 3, v: 0, hs: 1'b0, vs: 1'b0, de: 1'b1, le: 1'b0, fe: 1'b0};
    tbl[5]  = '{en: 1'b1, h: 4, v: 0, hs: 1'b0, vs: 1'b0, de: 1'b0, le: 1'b0, fe: 1'b0};
    tbl[6]  = '{en: 1'b1, h: 5, v: 0, hs: 1'b1, vs: 1'b0, de: 1'b0, le: 1'b0, fe: 1'b0};
    tbl[7]  = '{en: 1'b1, h: 6, v: 0, hs: 1'b1, vs: 1'b0, de: 1'b0, le: 1'b0, fe: 1'b0};
    tbl[8]  = '{en: 1'b1, h: 7, v: 0, hs: 1'b0, vs: 1'b0, de: 1'b0, le: 1'b1, fe: 1'b0};
    tbl[9]  = '{en: 1'b0, h: 7, v: 0, hs: 1'b0, vs: 1'b0, de: 1'b0, le: 1'b1, fe: 1'b0};
    tbl[10] = '{en: 1'b1, h: 0, v: 1, hs: 1'b0, vs: 1'b0, de: 1'b1, le: 1'b0, fe: 1'b0};

    arst_n = 1'b0;
    en     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    cmp("reset.a.hsync", a_hs, 1);
    cmp("reset.b.hsync", b_hs, 0);
    arst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].en);
      cmp("tbl.h_count", b_h, tbl[i].h);
      cmp("tbl.v_count", b_v, tbl[i].v);
      cmp("tbl.hsync", b_hs, tbl[i].hs);
      cmp("tbl.vsync", b_vs, tbl[i].vs);
      cmp("tbl.de", b_de, tbl[i].de);
      cmp("tbl.line_end", b_le, tbl[i].le);
      cmp("tbl.frame_end", b_fe, tbl[i].fe);
    end

    // One full small frame starting just after a frame_end.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1'b1);
      found = b_fe;
    end
    cmp("b.frame_end_reached", found, 1);
    de_cnt = 0; fe_cnt = 0; le_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'b1);
      de_cnt += b_de; fe_cnt += b_fe; le_cnt += b_le; hs_cnt += b_hs; vs_cnt += b_vs;
    end
    cmp("b.frame_de_cycles", de_cnt, 12);
    cmp("b.frame_end_cycles", fe_cnt, 1);
    cmp("b.line_end_cycles", le_cnt, 6);
    cmp("b.hsync_cycles", hs_cnt, 12);
    cmp("b.vsync_cycles", vs_cnt, 8);

    // Two default lines with en held high.
    de_cnt = 0; le_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      step(1'b1);
      de_cnt += a_de; le_cnt += a_le; hs_cnt += (a_hs == 1'b0);
    end
    cmp("a.line_de_cycles", de_cnt, 1280);
    cmp("a.line_end_cycles", le_cnt, 2);
    cmp("a.hsync_low_cycles", hs_cnt, 192);

    // en pattern 1-0-0-0: one default line spans 3200 clocks.
    le_cnt = 0;
    for (int i = 0; i < 3200; i++) begin
      step(i % 4 == 0);
      le_cnt += (a_le && en);
    end
    cmp("a.en_pattern_line_ends", le_cnt, 1);

    // Random enable.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0);
    end

    // Asynchronous reset asserted between clock edges.
    #2;
    arst_n = 1'b0;
    #1;
    n = 0;
    fc_start = 0;
    cmp("arst.a.h_count", a_h, 0);
    cmp("arst.a.v_count", a_v, 0);
    cmp("arst.a.hsync", a_hs, 1);
    cmp("arst.a.vsync", a_vs, 1);
    cmp("arst.a.de", a_de, 0);
    cmp("arst.b.hsync", b_hs, 0);
    check_all();
    #2;
    arst_n = 1'b1;
    step(1'b1);
    cmp("arst.a.first_de", a_de, 1);
    cmp("arst.a.first_h", a_h, 1);
    cmp("arst.b.first_de", b_de, 1);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Realign to a fresh reset so 144 enabled edges make exactly three small frames.
    #2;
    arst_n = 1'b0;
    #1;
    n = 0;
    fc_start = 0;
    #2;
    arst_n = 1'b1;
    for (int i = 0; i < 144; i++) step(1'b1);
    cmp("b.frame_cnt_after_144", b_fc, 3);
    force dut_b.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_b.frame_cnt_q;
    fc_start = 65535 - n / 48;
    for (int i = 0; i < 48; i++) step(1'b1);
    cmp("b.frame_cnt_wrap", b_fc, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Replaces the separate fixed-count horizontal and vertical counters with one block that has:
- configurable porch, sync and visible spans
- configurable sync polarity
- registered hsync, vsync and display-enable outputs
- line-end and frame-end flags

It sits between the pixel-clock enable source and the pixel pipeline or DAC output stage.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level (0 = active-low)
CW, 10, counter width

Ports:
clk  in  1  system clock
arst_n  in  1  reset, asynchronous, active-low
en  in  1  pixel-clock enable; all state advances only when en=1
h_count  out  CW  current pixel column, 0..H_TOTAL-1
v_count  out  CW  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity set by H_SYNC_POL
vsync  out  1  vertical sync, polarity set by V_SYNC_POL
de  out  1  display enable: 1 in the visible region
line_end  out  1  1 while h_count = H_TOTAL-1
frame_end  out  1  1 while h_count = H_TOTAL-1 and v_count = V_TOTAL-1

Behaviour:
- Derived spans:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK
- Elaboration-time checks (fatal $error on failure):
  - H_TOTAL-1 and V_TOTAL-1 must fit in CW bits
  - every span must be at least 1
- Reset (arst_n=0, takes effect immediately, asynchronously):
  - h_count = 0, v_count = 0
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL
  - de = 0, line_end = 0, frame_end = 0
- Counters, on each clk edge with en=1:
  - h_count = H_TOTAL-1: h_count wraps to 0. On that same edge, v_count increments, or wraps to 0 if v_count = V_TOTAL-1.
  - otherwise: h_count increments.
- en=0: every register holds, including all outputs.
- All outputs are flops, updated on the same edge as the counters and decoded from the next-state counter values. Zero-cycle skew between a counter value and its decodes.
- Decodes (hn, vn = next h_count, next v_count):
  - hsync active iff H_VISIBLE+H_FRONT ≤ hn < H_VISIBLE+H_FRONT+H_SYNC
  - vsync active iff V_VISIBLE+V_FRONT ≤ vn < V_VISIBLE+V_FRONT+V_SYNC
  - vsync is line-aligned: it changes only on the edge where h wraps
  - de = (hn < H_VISIBLE) && (vn < V_VISIBLE)
  - line_end = (hn = H_TOTAL-1)
  - frame_end = line_end && (vn = V_TOTAL-1)
- After reset, outputs first become consistent with the counters on the first en=1 edge. Until then de=0 although the counters read (0,0).
- line_end and frame_end are level flags, held while en=0. Downstream must qualify them with en to obtain single-event pulses.
- Reset mid-frame abandons the frame. There is no partial-frame recovery; counting restarts from (0,0).

Optional Feature:
Macro VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - adds output port frame_cnt (16 bits, out), reset 0
  - increments on each edge where en=1 and the frame wraps (h = H_TOTAL-1, v = V_TOTAL-1)
  - wraps 0xFFFF → 0x0000
- Not defined: the port and its logic are absent; the rest of the behaviour is identical.

Test Plan:
1. Default parameters, en held 1 after reset → h_count runs 0..799 then back to 0; line period 800 cycles; hsync=0 exactly while h_count ∈ [656,751]; line_end=1 only at h_count=799.
2. Default parameters, full frame → v_count advances only on the h wrap; vsync=0 exactly while v_count ∈ [490,491]; de=1 iff h<640 and v<480 (307200 de cycles per frame); frame period 420000 cycles; frame_end at (799,524) only.
3. en pattern 1-0-0-0 repeating → counters and outputs advance once per 4 clocks; a full line takes 3200 clocks; all outputs stable during en=0 cycles.
4. Drive arst_n low asynchronously mid-cycle at (300,200) → immediately h=v=0, hsync=vsync=1, de=0; after release with en=1, counting restarts from 0 and de rises on the first enabled edge.
5. H=4/1/2/1, V=3/1/1/1, H_SYNC_POL=V_SYNC_POL=1, CW=4 → H_TOTAL=8, hsync=1 at h∈{5,6}; V_TOTAL=6, vsync=1 at v=4; frame period 48 cycles. CW=2 with the default spans → elaboration error.
6. VGA_TIMING_FRAME_CNT_EN defined, en=1, small parameters from scenario 5 → frame_cnt = 3 after 144 cycles; preloaded/forced to 0xFFFF, wraps to 0 at the next frame end.
